// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_pkg : shared types, defaults and helpers for the PWM feed path    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pwm_pkg;

  localparam int DC_WIDTH_DEF = 8;
  localparam int N_CH_DEF     = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    DROP = 2'd2
  } fill_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_strobe_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_strobe_gen : prescaled STB_CLK strobe plus PWM period counter     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pwm_strobe_gen
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int DC_WIDTH = DC_WIDTH_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic STB_CLK,
  output logic PERIOD_END
);

  localparam int c_PRE_W = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);

  logic [c_PRE_W-1:0]  r_pre_cnt;
  logic [c_PRE_W-1:0]  w_pre_nxt;
  logic [DC_WIDTH-1:0] r_per_cnt;
  logic                r_stb;

  assign w_pre_nxt = (r_pre_cnt == c_PRE_LAST) ? '0 : r_pre_cnt + 1'b1;

  // Strobe is registered from the next count so it lines up with pre_cnt==PRESCALE-1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pre_cnt <= '0;
      r_stb     <= 1'b0;
      r_per_cnt <= '0;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_stb     <= (w_pre_nxt == c_PRE_LAST);
      if (r_stb) r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  assign STB_CLK    = r_stb;
  assign PERIOD_END = r_stb && (&r_per_cnt);

endmodule
`default_nettype wire

// File: rtl/pwm_dc_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_dc_loader : double-buffered duty-cycle row loader for PWM bank    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pwm_dc_loader
  import pwm_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int DC_WIDTH = DC_WIDTH_DEF,
  parameter int PRESCALE = 4,
  parameter int N_ROWS   = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [DC_WIDTH-1:0]        IN_DATA,
  input  logic                       IN_LAST,
  output logic                       STB_CLK,
  output logic [N_CH*DC_WIDTH-1:0]   DC_BUS,
  output logic [clog2(N_ROWS)-1:0]   ROW_SEL,
  output logic                       ROW_EN,
  output logic                       FRAME_START,
  output logic                       UNDERRUN,
  output logic                       ERR_LEN
);

  localparam int c_IDX_W = (clog2(N_CH) > 0) ? clog2(N_CH) : 1;
  localparam int c_ROW_W = clog2(N_ROWS);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_CH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(N_ROWS - 1);

  fill_state_t               r_state;
  fill_state_t               w_state_nxt;
  logic [c_IDX_W-1:0]        r_idx;
  logic [c_IDX_W-1:0]        w_idx_nxt;
  logic                      w_xfer;
  logic                      w_wr_en;
  logic                      w_err_len;
  logic                      w_swap;
  logic                      w_period_end;
  logic [DC_WIDTH-1:0]       r_shadow [N_CH];
  logic [N_CH*DC_WIDTH-1:0]  w_shadow_flat;
  logic                      r_ready;
  logic [N_CH*DC_WIDTH-1:0]  r_dc_bus;
  logic [c_ROW_W-1:0]        r_row_sel;
  logic                      r_row_en;
  logic                      r_frame_start;
  logic                      r_underrun;
  logic                      r_err_len;

  pwm_strobe_gen #(
    .PRESCALE (PRESCALE),
    .DC_WIDTH (DC_WIDTH)
  ) u_strobe (
    .CLK        (CLK),
    .RESET      (RESET),
    .STB_CLK    (STB_CLK),
    .PERIOD_END (w_period_end)
  );

  assign w_xfer = IN_VALID && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_err_len   = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_xfer) begin
          w_wr_en = 1'b1;
          if (r_idx == c_IDX_LAST) begin
            w_idx_nxt = '0;
            if (IN_LAST) begin
              w_state_nxt = FULL;
            end else begin
              w_err_len   = 1'b1;
              w_state_nxt = DROP;
            end
          end else if (IN_LAST) begin
            w_err_len = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      DROP: begin
        if (w_xfer && IN_LAST) w_state_nxt = FILL;
      end
      FULL: begin
        // Only a row that was already complete at the start of the cycle may swap.
        if (w_period_end) begin
          w_swap      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= FILL;
      r_idx         <= '0;
      r_ready       <= 1'b0;
      r_dc_bus      <= '0;
      r_row_sel     <= '0;
      r_row_en      <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_ready       <= (w_state_nxt != FULL);
      r_err_len     <= w_err_len;
      r_underrun    <= w_period_end && (r_state != FULL);
      r_frame_start <= 1'b0;
      if (w_swap) begin
        r_dc_bus <= w_shadow_flat;
        r_row_en <= 1'b1;
        if (r_row_sel == c_ROW_LAST) begin
          r_row_sel     <= '0;
          r_frame_start <= 1'b1;
        end else begin
          r_row_sel <= r_row_sel + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < N_CH; k++) r_shadow[k] <= '0;
    end else if (w_wr_en) begin
      r_shadow[r_idx] <= IN_DATA;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_flat
    assign w_shadow_flat[k*DC_WIDTH +: DC_WIDTH] = r_shadow[k];
  end

  assign IN_READY    = r_ready;
  assign DC_BUS      = r_dc_bus;
  assign ROW_SEL     = r_row_sel;
  assign ROW_EN      = r_row_en;
  assign FRAME_START = r_frame_start;
  assign UNDERRUN    = r_underrun;
  assign ERR_LEN     = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_pwm_dc_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_pwm_dc_loader : directed self-checking bench for pwm_dc_loader     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pwm_dc_loader;

  localparam int PER = 1024;

  logic        CLK;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_DATA;
  logic        IN_LAST;
  logic        STB_CLK;
  logic [63:0] DC_BUS;
  logic [2:0]  ROW_SEL;
  logic        ROW_EN;
  logic        FRAME_START;
  logic        UNDERRUN;
  logic        ERR_LEN;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int n_frame = 0;
  int n_under = 0;
  logic [63:0] exp_bus;
  logic [2:0]  exp_row;
  int base;

  pwm_dc_loader #(
    .N_CH(8), .DC_WIDTH(8), .PRESCALE(4), .N_ROWS(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .STB_CLK(STB_CLK), .DC_BUS(DC_BUS),
    .ROW_SEL(ROW_SEL), .ROW_EN(ROW_EN), .FRAME_START(FRAME_START),
    .UNDERRUN(UNDERRUN), .ERR_LEN(ERR_LEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle index since reset release: cycle 0 is the cycle before the first edge.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      if (FRAME_START) n_frame <= n_frame + 1;
      if (UNDERRUN)    n_under <= n_under + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] word_of(input int seed, input int k);
    logic [7:0] a;
    logic [7:0] b;
    a = 8'(k * 17);
    b = 8'((seed & 15) << 4);
    return a ^ b;
  endfunction

  function automatic logic [63:0] row_bus(input int seed);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = word_of(seed, k);
    return v;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic send_word(input logic [7:0] d, input logic last);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = last;
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic send_row(input int seed, input int n);
    for (int k = 0; k < n; k++) send_word(word_of(seed, k), k == n - 1);
  endtask

  task automatic test_reset;
    RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0;
    #12;
    vectors++;
    if ({IN_READY, STB_CLK, ROW_EN, FRAME_START, UNDERRUN, ERR_LEN} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
                         {IN_READY, STB_CLK, ROW_EN, FRAME_START, UNDERRUN, ERR_LEN});
    end
    vectors++;
    if (DC_BUS !== 64'h0 || ROW_SEL !== 3'd0) begin
      errors++; $display("FAIL reset_bus: got %h/%0d expected 0/0", DC_BUS, ROW_SEL);
    end
    @(negedge CLK);
    RESET = 1'b0;
    exp_bus = '0; exp_row = '0;
    wait_cyc(1);
    vectors++;
    if (IN_READY !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b expected 1", IN_READY);
    end
  endtask

  task automatic test_idle;
    for (int c = 1; c <= 12; c++) begin
      wait_cyc(c);
      vectors++;
      if (STB_CLK !== ((c % 4) == 3)) begin
        errors++; $display("FAIL stb_cycle%0d: got %b expected %b", c, STB_CLK, (c % 4) == 3);
      end
    end
    wait_cyc(PER - 1);
    vectors++;
    if (UNDERRUN !== 1'b0) begin
      errors++; $display("FAIL underrun_early: got %b expected 0", UNDERRUN);
    end
    wait_cyc(PER);
    vectors++;
    if (UNDERRUN !== 1'b1 || DC_BUS !== 64'h0 || ROW_EN !== 1'b0 || ROW_SEL !== 3'd0) begin
      errors++; $display("FAIL idle_underrun: got u=%b bus=%h en=%b row=%0d expected 1/0/0/0",
                         UNDERRUN, DC_BUS, ROW_EN, ROW_SEL);
    end
    wait_cyc(PER + 1);
    vectors++;
    if (UNDERRUN !== 1'b0) begin
      errors++; $display("FAIL underrun_width: got %b expected 0", UNDERRUN);
    end
    wait_cyc(2 * PER);
    vectors++;
    if (UNDERRUN !== 1'b1) begin
      errors++; $display("FAIL underrun_second: got %b expected 1", UNDERRUN);
    end
  endtask

  task automatic test_first_row;
    base = 2 * PER;
    wait_cyc(base + 2);
    send_row(0, 8);
    vectors++;
    if (IN_READY !== 1'b0) begin
      errors++; $display("FAIL ready_full: got %b expected 0", IN_READY);
    end
    wait_cyc(base + PER - 1);
    vectors++;
    if (DC_BUS !== 64'h0) begin
      errors++; $display("FAIL bus_before_swap: got %h expected 0", DC_BUS);
    end
    wait_cyc(base + PER);
    exp_bus = 64'h7766554433221100; exp_row = 3'd1;
    vectors++;
    if (DC_BUS !== exp_bus || ROW_SEL !== exp_row || ROW_EN !== 1'b1 || UNDERRUN !== 1'b0) begin
      errors++; $display("FAIL first_swap: got bus=%h row=%0d en=%b u=%b expected %h/1/1/0",
                         DC_BUS, ROW_SEL, ROW_EN, UNDERRUN, exp_bus);
    end
    vectors++;
    if (IN_READY !== 1'b1) begin
      errors++; $display("FAIL ready_after_swap: got %b expected 1", IN_READY);
    end
  endtask

  task automatic test_back_to_back;
    int u0;
    int f0;
    u0 = n_under; f0 = n_frame;
    for (int i = 1; i <= 8; i++) begin
      base = PER * (2 + i);
      wait_cyc(base + 2);
      send_row(i, 8);
      wait_cyc(base + PER);
      exp_bus = row_bus(i);
      exp_row = exp_row + 3'd1;
      vectors++;
      if (DC_BUS !== exp_bus || ROW_SEL !== exp_row || FRAME_START !== (exp_row == 3'd0)) begin
        errors++; $display("FAIL b2b_row%0d: got bus=%h row=%0d fs=%b expected %h/%0d/%b",
                           i, DC_BUS, ROW_SEL, FRAME_START, exp_bus, exp_row, exp_row == 3'd0);
      end
    end
    @(negedge CLK);
    vectors++;
    if (n_frame - f0 != 1 || n_under != u0) begin
      errors++; $display("FAIL b2b_counts: got frames=%0d underruns=%0d expected 1/0",
                         n_frame - f0, n_under - u0);
    end
  endtask

  task automatic test_short_row;
    base = PER * 11;
    wait_cyc(base + 2);
    send_row(9, 5);
    vectors++;
    if (ERR_LEN !== 1'b1) begin
      errors++; $display("FAIL short_err: got %b expected 1", ERR_LEN);
    end
    @(negedge CLK);
    vectors++;
    if (ERR_LEN !== 1'b0 || IN_READY !== 1'b1) begin
      errors++; $display("FAIL short_after: got err=%b rdy=%b expected 0/1", ERR_LEN, IN_READY);
    end
    wait_cyc(base + PER);
    vectors++;
    if (DC_BUS !== exp_bus || ROW_SEL !== exp_row || UNDERRUN !== 1'b1) begin
      errors++; $display("FAIL short_underrun: got bus=%h row=%0d u=%b expected %h/%0d/1",
                         DC_BUS, ROW_SEL, UNDERRUN, exp_bus, exp_row);
    end
    wait_cyc(base + PER + 2);
    send_row(10, 8);
    wait_cyc(base + 2 * PER);
    exp_bus = row_bus(10); exp_row = exp_row + 3'd1;
    vectors++;
    if (DC_BUS !== exp_bus || ROW_SEL !== exp_row || UNDERRUN !== 1'b0) begin
      errors++; $display("FAIL short_recover: got bus=%h row=%0d u=%b expected %h/%0d/0",
                         DC_BUS, ROW_SEL, UNDERRUN, exp_bus, exp_row);
    end
  endtask

  task automatic test_long_row;
    base = PER * 13;
    wait_cyc(base + 2);
    for (int k = 0; k < 10; k++) begin
      send_word(word_of(11, k), k == 9);
      if (k == 7) begin
        vectors++;
        if (ERR_LEN !== 1'b1) begin
          errors++; $display("FAIL long_err: got %b expected 1", ERR_LEN);
        end
      end
      if (k == 8) begin
        vectors++;
        if (ERR_LEN !== 1'b0 || IN_READY !== 1'b1) begin
          errors++; $display("FAIL long_drop: got err=%b rdy=%b expected 0/1", ERR_LEN, IN_READY);
        end
      end
    end
    vectors++;
    if (IN_READY !== 1'b1 || ERR_LEN !== 1'b0) begin
      errors++; $display("FAIL long_end: got rdy=%b err=%b expected 1/0", IN_READY, ERR_LEN);
    end
    send_row(12, 8);
    wait_cyc(base + PER);
    exp_bus = row_bus(12); exp_row = exp_row + 3'd1;
    vectors++;
    if (DC_BUS !== exp_bus || ROW_SEL !== exp_row || UNDERRUN !== 1'b0) begin
      errors++; $display("FAIL long_recover: got bus=%h row=%0d u=%b expected %h/%0d/0",
                         DC_BUS, ROW_SEL, UNDERRUN, exp_bus, exp_row);
    end
  endtask

  task automatic test_boundary_complete;
    base = PER * 14;
    // Eighth word transfers on the edge that closes the period_end cycle.
    wait_cyc(base + PER - 1 - 7);
    send_row(13, 8);
    wait_cyc(base + PER);
    vectors++;
    if (UNDERRUN !== 1'b1 || DC_BUS !== exp_bus || ROW_SEL !== exp_row || IN_READY !== 1'b0) begin
      errors++; $display("FAIL boundary_noswap: got u=%b bus=%h row=%0d rdy=%b expected 1/%h/%0d/0",
                         UNDERRUN, DC_BUS, ROW_SEL, IN_READY, exp_bus, exp_row);
    end
    wait_cyc(base + 2 * PER);
    exp_bus = row_bus(13); exp_row = exp_row + 3'd1;
    vectors++;
    if (UNDERRUN !== 1'b0 || DC_BUS !== exp_bus || ROW_SEL !== exp_row) begin
      errors++; $display("FAIL boundary_swap: got u=%b bus=%h row=%0d expected 0/%h/%0d",
                         UNDERRUN, DC_BUS, ROW_SEL, exp_bus, exp_row);
    end
  endtask

  task automatic test_reset_mid_fill;
    base = PER * 16;
    wait_cyc(base + 2);
    send_row(14, 3);
    IN_VALID = 1'b1; IN_DATA = 8'hA5; IN_LAST = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    vectors++;
    if (DC_BUS !== 64'h0 || ROW_SEL !== 3'd0 || ROW_EN !== 1'b0 || IN_READY !== 1'b0 ||
        STB_CLK !== 1'b0 || UNDERRUN !== 1'b0 || ERR_LEN !== 1'b0 || FRAME_START !== 1'b0) begin
      errors++; $display("FAIL async_reset: got bus=%h row=%0d en=%b rdy=%b stb=%b expected all 0",
                         DC_BUS, ROW_SEL, ROW_EN, IN_READY, STB_CLK);
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    wait_cyc(2);
    send_row(15, 8);
    wait_cyc(PER);
    exp_bus = row_bus(15);
    vectors++;
    if (DC_BUS !== exp_bus || ROW_SEL !== 3'd1 || ROW_EN !== 1'b1) begin
      errors++; $display("FAIL post_reset_swap: got bus=%h row=%0d en=%b expected %h/1/1",
                         DC_BUS, ROW_SEL, ROW_EN, exp_bus);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_row();
    test_back_to_back();
    test_short_row();
    test_long_row();
    test_boundary_complete();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_dc_loader.md
Name: pwm_dc_loader

Overview:
- Upstream feeder for the LED-matrix PWM channel bank.
- Accepts a stream of per-channel duty-cycle words, one row at a time, over a valid/ready handshake.
- Double-buffers each row and swaps it onto the parallel DC bus only at a PWM period boundary, so duty cycles never change mid-period.
- Generates the shared STB_CLK strobe for all PWM instances and advances the row select on each swap.

Parameters:
N_CH, 8, number of PWM channels per row (words per row)
DC_WIDTH, 8, duty-cycle width in bits; the PWM period is 2^DC_WIDTH strobes
PRESCALE, 4, CLK cycles per STB_CLK pulse (>=1)
N_ROWS, 8, rows scanned per frame (>=2)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
IN_VALID  in  1  upstream word valid
IN_READY  out  1  block can accept a word
IN_DATA  in  DC_WIDTH  duty-cycle word, channel 0 first
IN_LAST  in  1  marks the final word of a row
STB_CLK  out  1  one-CLK strobe to the PWM bank
DC_BUS  out  N_CH*DC_WIDTH  active duty cycles; channel k at bits [k*DC_WIDTH +: DC_WIDTH]
ROW_SEL  out  clog2(N_ROWS)  active row index
ROW_EN  out  1  row drivers enabled
FRAME_START  out  1  one-CLK pulse when ROW_SEL wraps to 0
UNDERRUN  out  1  one-CLK pulse when a period ends with no full shadow row
ERR_LEN  out  1  one-CLK pulse on a malformed row

Behaviour:
- Reset: the reset is asynchronous, active-high on RESET; the clock is CLK. All registers clear. IN_READY=0, STB_CLK=0, DC_BUS=0, ROW_SEL=0, ROW_EN=0, and all pulse outputs are 0. In the first cycle after release, IN_READY=1.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - STB_CLK=1 (registered) in the cycle where pre_cnt==PRESCALE-1.
  - PRESCALE=1 gives STB_CLK high every cycle.
- Period counter:
  - per_cnt (DC_WIDTH bits) increments on each STB_CLK and wraps naturally.
  - period_end = STB_CLK && per_cnt==all-ones. This occurs every PRESCALE*2^DC_WIDTH cycles.
- Fill state machine, states FILL and FULL:
  - FILL: IN_READY=1. A word transfers when IN_VALID&&IN_READY; it is written to shadow[idx] and idx increments.
    - idx==N_CH-1 with IN_LAST=1: go to FULL, idx=0.
    - IN_LAST=1 with idx<N_CH-1 (short row): ERR_LEN pulse, idx=0, stay in FILL, shadow content discarded.
    - idx==N_CH-1 with IN_LAST=0 (long row): word written, ERR_LEN pulse, then enter DROP.
  - DROP: IN_READY=1. Words are consumed and ignored until a transfer with IN_LAST=1, then go to FILL with idx=0.
  - FULL: IN_READY=0. Wait for period_end.
- Swap at period_end, when state==FULL at the start of the cycle:
  - DC_BUS <= shadow; ROW_SEL <= ROW_SEL+1, wrapping N_ROWS-1 -> 0.
  - FRAME_START pulses on the wrap. ROW_EN <= 1 and stays 1 until reset.
  - State -> FILL. IN_READY=1 from the next cycle.
- Underrun: a period_end with state!=FULL pulses UNDERRUN. DC_BUS and ROW_SEL hold; ROW_EN is unchanged.
- Simultaneous events: if the final word of a row completes in the same cycle as period_end, that cycle counts as an underrun and the swap waits for the next period_end. No same-cycle bypass.
- Latency:
  - Swapped DC_BUS and ROW_SEL are visible in the cycle after period_end.
  - This coincides with per_cnt==0, the first strobe of the new period PRESCALE-1 cycles later.
- Reset mid-operation: a partially filled shadow is discarded and the DC_BUS returns to 0.
- Widths: the index width is clog2(N_CH). No arithmetic on the data; words pass unmodified.

Decomposition:
- Shared package pwm_pkg:
  - fill-state enum (FILL, FULL, DROP)
  - clog2 function
  - default constants DC_WIDTH_DEF=8, N_CH_DEF=8
- One natural sub-module, pwm_strobe_gen: the prescaler plus period counter. It outputs STB_CLK and period_end and is reusable by other PWM consumers.
- The fill FSM, shadow and active registers stay in the top module.

Test Plan:
All scenarios use PRESCALE=4, DC_WIDTH=8, N_CH=8, N_ROWS=8, so the period is 1024 cycles.
1. Release reset, idle -> STB_CLK every 4th cycle; UNDERRUN pulses at cycle 1024 and every 1024 thereafter; DC_BUS=0, ROW_EN=0.
2. Stream words 0x00,0x11..0x77 with IN_LAST on the 8th -> IN_READY drops after the 8th word; at the next period_end DC_BUS=0x7766554433221100, ROW_SEL=1, ROW_EN=1, no UNDERRUN.
3. Feed 8 full rows back-to-back, each ahead of its period -> ROW_SEL steps 1..7,0; FRAME_START pulses exactly once, on the 0 wrap; UNDERRUN never fires.
4. Short row (IN_LAST on word 5) -> ERR_LEN one pulse, DC_BUS unchanged at the next period_end plus an UNDERRUN pulse; the next correct 8-word row swaps normally.
5. Long row (10 words, IN_LAST on 10th) -> ERR_LEN on word 8, words 9-10 accepted and dropped, the state returns to FILL, and the next row is captured correctly.
6. Complete the 8th word exactly on the period_end cycle -> UNDERRUN pulses, no swap; the swap occurs 1024 cycles later. Then assert RESET mid-fill -> all outputs return to reset values asynchronously.
